// File: rtl/audio_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : audio_pkg
// Description : Shared stereo field layout, 16-bit saturation limits, the
//               echo FSM state encoding and the sat16 clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int c_L_HI = 31;
    localparam int c_L_LO = 16;
    localparam int c_R_HI = 15;
    localparam int c_R_LO = 0;

    localparam logic signed [15:0] c_SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] c_SAT_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_MIX   = 3'd3,
        ST_WRITE = 3'd4
    } echo_state_t;

    // Overflow shows up as the two top bits of the 17-bit sum disagreeing.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
        if (x[16] != x[15]) begin
            return x[16] ? c_SAT_MIN : c_SAT_MAX;
        end
        return x[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_buffer_ram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : echo_buffer_ram
// Description : Simple dual-port RAM, one write port and one synchronous
//               read port with a single cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_buffer_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // No reset on the read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_echo_effect.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : audio_echo_effect
// Description : Stereo feedback echo: mixes each input sample with a decayed
//               copy of the output from `delay` samples earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_echo_effect
    import audio_pkg::*;
#(
    parameter int DEPTH_LOG2  = 12,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [31:0]           audioIn,
    input  logic                  enable,
    input  logic [DEPTH_LOG2-1:0] delay,
    output logic [31:0]           audioOut,
    output logic                  out_valid,
    output logic                  ready,
    output logic                  overrun
);

    localparam logic [DEPTH_LOG2-1:0] c_LAST_ADDR = '1;

    echo_state_t           r_state;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_clr_addr;
    logic [31:0]           r_in;
    logic                  r_en;

    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_waddr;
    logic [31:0]           w_wdata;
    logic                  w_re;
    logic [DEPTH_LOG2-1:0] w_raddr;
    logic [31:0]           w_rdata;

    logic signed [15:0]    w_echo_l;
    logic signed [15:0]    w_echo_r;
    logic signed [16:0]    w_sum_l;
    logic signed [16:0]    w_sum_r;
    logic [31:0]           w_mix;

    // The write port is shared between the clear sweep and the feedback write.
    always_comb begin
        w_we    = (r_state == ST_CLEAR) || ((r_state == ST_WRITE) && !rst);
        w_waddr = (r_state == ST_CLEAR) ? r_clr_addr : r_wr_ptr;
        w_wdata = ((r_state == ST_WRITE) && r_en) ? audioOut : 32'd0;
        w_re    = (r_state == ST_IDLE) && sample_valid;
        w_raddr = r_wr_ptr - delay;
    end

    echo_buffer_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (32)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_echo_l = $signed(w_rdata[c_L_HI:c_L_LO]) >>> DECAY_SHIFT;
        w_echo_r = $signed(w_rdata[c_R_HI:c_R_LO]) >>> DECAY_SHIFT;
        w_sum_l  = $signed({r_in[c_L_HI], r_in[c_L_HI:c_L_LO]}) + $signed({w_echo_l[15], w_echo_l});
        w_sum_r  = $signed({r_in[c_R_HI], r_in[c_R_HI:c_R_LO]}) + $signed({w_echo_r[15], w_echo_r});
        w_mix    = r_en ? {sat16(w_sum_l), sat16(w_sum_r)} : r_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
            r_in       <= 32'd0;
            r_en       <= 1'b0;
            audioOut   <= 32'd0;
            out_valid  <= 1'b0;
            ready      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_LAST_ADDR) begin
                        r_wr_ptr <= '0;
                        ready    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sample_valid) begin
                        r_in    <= audioIn;
                        r_en    <= enable;
                        ready   <= 1'b0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_MIX;
                end
                ST_MIX: begin
                    audioOut  <= w_mix;
                    out_valid <= 1'b1;
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    ready    <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    ready   <= 1'b0;
                    r_state <= ST_CLEAR;
                end
            endcase
            if (sample_valid && ((r_state == ST_READ) || (r_state == ST_MIX) ||
                                 (r_state == ST_WRITE))) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
